// File: rtl/mem_stage_dmem_responder_if.sv
// Request/response bundle between the X->M pipeline register and the data-memory responder.
// The master side is the pipeline register; the slave side is the responder.
interface mem_stage_dmem_responder_if;
    logic [31:0] address_in;
    logic [31:0] data_in;
    logic        mem_read_write_in;
    logic        mem_enable_in;
    logic [31:0] data_out;
    logic        mem_ready;
    logic        mem_error;
    logic        mem_busy;

    modport master (
        output address_in, data_in, mem_read_write_in, mem_enable_in,
        input  data_out, mem_ready, mem_error, mem_busy
    );

    modport slave (
        input  address_in, data_in, mem_read_write_in, mem_enable_in,
        output data_out, mem_ready, mem_error, mem_busy
    );
endinterface

// File: rtl/mem_stage_dmem_responder.sv
// Word-wide data-memory responder with WAIT_STATES extra access cycles (IDLE -> ACCESS -> DONE).
// Optional feature: define DMEM_MISALIGN_TRAP_EN to fault accesses with address[1:0] != 0.
module mem_stage_dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input logic clock,
    input logic reset_n,
    mem_stage_dmem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      req_addr;
    logic [31:0]      req_data;
    logic             req_write;
    logic [31:0]      ram [DEPTH_WORDS];

    logic [31:0]      acc_addr;
    logic [31:0]      acc_data;
    logic             acc_write;
    logic [IDX_W-1:0] word_idx;
    logic             out_of_range;
    logic             misaligned;
    logic             fault;
    logic             finishing;

    // With zero wait states the access happens on the accepting edge, so decode straight from the inputs.
    always_comb begin
        acc_addr  = (state == IDLE) ? bus.address_in        : req_addr;
        acc_data  = (state == IDLE) ? bus.data_in           : req_data;
        acc_write = (state == IDLE) ? bus.mem_read_write_in : req_write;
        word_idx  = acc_addr[IDX_W+1:2];
        out_of_range = |acc_addr[31:IDX_W+2];
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned = |acc_addr[1:0];
`else
        misaligned = 1'b0;
`endif
        fault = out_of_range | misaligned;
        finishing = reset_n &&
                    (((state == IDLE) && bus.mem_enable_in && (WAIT_STATES == 0)) ||
                     ((state == ACCESS) && (wait_cnt == '0)));
    end

`ifndef DMEM_MISALIGN_TRAP_EN
    logic unused_low_bits;
    assign unused_low_bits = ^acc_addr[1:0];
`endif

    assign bus.mem_busy = reset_n &&
                          ((state == ACCESS) || ((state == IDLE) && bus.mem_enable_in));

    // RAM has no reset so its contents survive reset_n; a write only lands on the edge entering DONE.
    always_ff @(posedge clock) begin
        if (finishing && acc_write && !fault) begin
            ram[word_idx] <= acc_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            req_addr      <= '0;
            req_data      <= '0;
            req_write     <= 1'b0;
            bus.data_out  <= '0;
            bus.mem_ready <= 1'b0;
            bus.mem_error <= 1'b0;
        end else begin
            bus.mem_ready <= 1'b0;
            bus.mem_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mem_enable_in) begin
                        req_addr  <= bus.address_in;
                        req_data  <= bus.data_in;
                        req_write <= bus.mem_read_write_in;
                        if (WAIT_STATES == 0) begin
                            state <= DONE;
                        end else begin
                            state    <= ACCESS;
                            wait_cnt <= CNT_W'(WAIT_STATES - 1);
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Completion results appear in the DONE cycle alongside the ready pulse.
            if (finishing) begin
                bus.mem_ready <= 1'b1;
                bus.mem_error <= fault;
                if (!acc_write) begin
                    bus.data_out <= fault ? 32'h0 : ram[word_idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_dmem_responder.sv
// Self-checking bench: one responder with two wait states and one with none, compared against a word-array model.
// Build with DMEM_MISALIGN_TRAP_EN defined to exercise the misalignment trap expectations.
module tb_mem_stage_dmem_responder;
    localparam int DEPTH = 256;
    localparam int WS_A  = 2;
    localparam int WS_B  = 0;

    logic clock;
    logic rst_a_n;
    logic rst_b_n;
    int   cyc;
    int   vectors;
    int   miscompares;

    mem_stage_dmem_responder_if bus_a();
    mem_stage_dmem_responder_if bus_b();

    mem_stage_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A)) dut_a (
        .clock   (clock),
        .reset_n (rst_a_n),
        .bus     (bus_a)
    );

    mem_stage_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_B)) dut_b (
        .clock   (clock),
        .reset_n (rst_b_n),
        .bus     (bus_b)
    );

    // Behavioural model: memory contents and last load result per instance.
    logic [31:0] model_mem   [2][DEPTH];
    bit          model_known [2][DEPTH];
    logic [31:0] model_dout  [2];
    int          last_ready_cyc;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int ws_of(input int sel);
        return (sel == 0) ? WS_A : WS_B;
    endfunction

    task automatic drive(input int sel, input logic en, input logic rw,
                         input logic [31:0] addr, input logic [31:0] data);
        if (sel == 0) begin
            bus_a.mem_enable_in = en; bus_a.mem_read_write_in = rw;
            bus_a.address_in = addr;  bus_a.data_in = data;
        end else begin
            bus_b.mem_enable_in = en; bus_b.mem_read_write_in = rw;
            bus_b.address_in = addr;  bus_b.data_in = data;
        end
    endtask

    task automatic sample(input int sel, output logic r, output logic e,
                          output logic b, output logic [31:0] d);
        if (sel == 0) begin
            r = bus_a.mem_ready; e = bus_a.mem_error; b = bus_a.mem_busy; d = bus_a.data_out;
        end else begin
            r = bus_b.mem_ready; e = bus_b.mem_error; b = bus_b.mem_busy; d = bus_b.data_out;
        end
    endtask

    task automatic idle(input int sel);
        @(negedge clock);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // One complete request: present it, hold it until ready, check timing and results against the model.
    task automatic run_txn(input int sel, input logic rw, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit perturb, input string name);
        logic r, e, b;
        logic [31:0] d;
        int lat, busy_cnt, idx;
        bit got, oor, mis, exp_err, exp_known;
        logic [31:0] exp_d;

        oor = (addr >= 32'(4 * DEPTH));
        mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (addr % 4) != 0;
`endif
        exp_err = oor || mis;
        idx = int'((addr / 4) % DEPTH);
        if (rw) begin
            exp_d = model_dout[sel]; exp_known = 1'b1;
        end else if (exp_err) begin
            exp_d = 32'h0; exp_known = 1'b1;
        end else begin
            exp_d = model_mem[sel][idx]; exp_known = model_known[sel][idx];
        end

        @(negedge clock);
        drive(sel, 1'b1, rw, addr, wdata);
        #1;
        sample(sel, r, e, b, d);
        vectors++;
        if (r !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s ready_at_request: got %b want 0", name, r);
        end
        busy_cnt = (b === 1'b1) ? 1 : 0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clock);
            lat++;
            sample(sel, r, e, b, d);
            if (r === 1'b1) got = 1'b1;
            else if (b === 1'b1) busy_cnt++;
            if (perturb && lat == 1)
                drive(sel, 1'b0, ~rw, $urandom, $urandom);
        end

        vectors++;
        if (!got) begin
            miscompares++;
            $display("[TB] FAIL %s ready_timeout: no ready in %0d cycles, want %0d", name, lat, 1 + ws_of(sel));
        end else begin
            if (cyc > 0) last_ready_cyc = cyc;
            vectors++;
            if (lat != 1 + ws_of(sel)) begin
                miscompares++;
                $display("[TB] FAIL %s latency: got %0d want %0d", name, lat, 1 + ws_of(sel));
            end
            vectors++;
            if (busy_cnt != 1 + ws_of(sel)) begin
                miscompares++;
                $display("[TB] FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, 1 + ws_of(sel));
            end
            vectors++;
            if (e !== exp_err) begin
                miscompares++;
                $display("[TB] FAIL %s mem_error: got %b want %b", name, e, exp_err);
            end
            if (exp_known) begin
                vectors++;
                if (d !== exp_d) begin
                    miscompares++;
                    $display("[TB] FAIL %s data_out: got %h want %h", name, d, exp_d);
                end
            end
        end

        if (rw && !exp_err) begin
            model_mem[sel][idx] = wdata;
            model_known[sel][idx] = 1'b1;
        end else if (!rw) begin
            model_dout[sel] = exp_d;
        end
    endtask

    task automatic check_no_ready(input int sel, input int cycles, input string name);
        logic r, e, b;
        logic [31:0] d;
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clock);
            #1;
            sample(sel, r, e, b, d);
            if (r !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("[TB] FAIL %s stray_ready: ready seen, want none", name);
        end
    endtask

    task automatic test_reset();
        logic r, e, b;
        logic [31:0] d;
        drive(0, 1'b1, 1'b1, 32'h10, 32'h1);
        drive(1, 1'b1, 1'b1, 32'h10, 32'h1);
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sample(s, r, e, b, d);
            vectors += 4;
            if (r !== 1'b0) begin miscompares++; $display("[TB] FAIL reset%0d ready: got %b want 0", s, r); end
            if (e !== 1'b0) begin miscompares++; $display("[TB] FAIL reset%0d error: got %b want 0", s, e); end
            if (b !== 1'b0) begin miscompares++; $display("[TB] FAIL reset%0d busy: got %b want 0", s, b); end
            if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL reset%0d data_out: got %h want 0", s, d); end
            model_dout[s] = 32'h0;
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clock);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
    endtask

    task automatic test_wait_states();
        run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "t1_write");
        run_txn(0, 1'b0, 32'h10, 32'h0, 1'b0, "t1_read");
        idle(0);
    endtask

    task automatic test_back_to_back();
        int prev;
        logic [31:0] addrs [4];
        logic [31:0] datas [4];
        logic        rws   [4];
        addrs = '{32'h0, 32'h0, 32'h4, 32'h4};
        datas = '{32'h1, 32'h0, 32'h2, 32'h0};
        rws   = '{1'b1, 1'b0, 1'b1, 1'b0};
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            run_txn(1, rws[i], addrs[i], datas[i], 1'b0, "t2_b2b");
            if (prev >= 0) begin
                vectors++;
                if (last_ready_cyc - prev != WS_B + 2) begin
                    miscompares++;
                    $display("[TB] FAIL t2_spacing: got %0d want %0d", last_ready_cyc - prev, WS_B + 2);
                end
            end
            prev = last_ready_cyc;
        end
        idle(1);
    endtask

    task automatic test_out_of_range();
        for (int s = 0; s < 2; s++) begin
            run_txn(s, 1'b1, 32'h0, 32'h0, 1'b0, "t3_init");
            run_txn(s, 1'b0, 32'h400, 32'h0, 1'b0, "t3_oor_read");
            run_txn(s, 1'b1, 32'h400, 32'h55, 1'b0, "t3_oor_write");
            run_txn(s, 1'b0, 32'h0, 32'h0, 1'b0, "t3_read0");
            idle(s);
        end
    endtask

    task automatic test_reset_mid_access();
        logic r, e, b;
        logic [31:0] d;
        run_txn(0, 1'b1, 32'h8, 32'h12345678, 1'b0, "t4_prior");
        @(negedge clock);
        drive(0, 1'b1, 1'b1, 32'h8, 32'h0000A5A5);
        @(negedge clock);
        rst_a_n = 1'b0;
        #1;
        sample(0, r, e, b, d);
        vectors += 4;
        if (r !== 1'b0) begin miscompares++; $display("[TB] FAIL t4 ready_in_reset: got %b want 0", r); end
        if (e !== 1'b0) begin miscompares++; $display("[TB] FAIL t4 error_in_reset: got %b want 0", e); end
        if (b !== 1'b0) begin miscompares++; $display("[TB] FAIL t4 busy_in_reset: got %b want 0", b); end
        if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL t4 data_in_reset: got %h want 0", d); end
        model_dout[0] = 32'h0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        rst_a_n = 1'b1;
        check_no_ready(0, 5, "t4_aborted");
        run_txn(0, 1'b0, 32'h8, 32'h0, 1'b0, "t4_read");
        idle(0);
    endtask

    task automatic test_misalign();
        run_txn(0, 1'b1, 32'h4, 32'h11, 1'b0, "t5_init");
        run_txn(0, 1'b1, 32'h6, 32'h77, 1'b0, "t5_write6");
        run_txn(0, 1'b0, 32'h4, 32'h0, 1'b0, "t5_read4");
        idle(0);
    endtask

    task automatic test_ignore_changes();
        run_txn(0, 1'b1, 32'h20, 32'hCAFE, 1'b1, "t6_write");
        check_no_ready(0, 5, "t6_no_second");
        run_txn(0, 1'b0, 32'h20, 32'h0, 1'b0, "t6_read");
        idle(0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 7) == 0)
                    addr = $urandom | 32'h0000_0400;
                else
                    addr = 32'($urandom_range(0, 4 * DEPTH - 1));
                run_txn(s, 1'($urandom_range(0, 1)), addr, $urandom,
                        (s == 0) && ($urandom_range(0, 3) == 0), "random");
            end
            idle(s);
        end
    endtask

    initial begin
        cyc = 0;
        vectors = 0;
        miscompares = 0;
        last_ready_cyc = 0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++) model_known[s][i] = 1'b0;
        test_reset();
        test_wait_states();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_access();
        test_misalign();
        test_ignore_changes();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
